// File: rtl/uart_msg_sender.sv
// uart_msg_sender: sends a programmable-length message buffer byte by byte to a UART TX core. Optional CR/LF suffix is enabled by the macro UART_MSG_CRLF_EN.
module uart_msg_sender #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              len_we,
    input  logic [ADDR_W:0]   len_in,
    input  logic              start,
    input  logic              abort,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] byte_idx
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, FINISH} state_t;
`ifdef UART_MSG_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [1:0]          sfx_q, sfx_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                last;

    function automatic logic [DATA_W-1:0] init_byte(input int i);
        return i == 0 ? DATA_W'(8'h68) : i == 1 ? DATA_W'(8'h65) :
               (i == 2 || i == 3) ? DATA_W'(8'h6C) : i == 4 ? DATA_W'(8'h6F) : '0;
    endfunction

    // next-state: buffer writes in IDLE, message sequencing, suffix phases (sfx 1=CR, 2=LF), abort override
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        sfx_d     = sfx_q;
        mem_d     = mem_q;
        tx_data_d = tx_data_q;
        last      = {1'b0, idx_q} == len_q - (ADDR_W+1)'(1);
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            idx_d   = '0;
            sfx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (wr_en) mem_d[wr_addr] = wr_data;
                    if (len_we) len_d = len_in > LEN_MAX ? LEN_MAX : len_in;
                    if (start && !abort) begin
                        idx_d   = '0;
                        sfx_d   = (len_q == '0 && CRLF) ? 2'd1 : 2'd0;
                        state_d = (len_q != '0 || CRLF) ? ISSUE : FINISH;
                    end
                end
                ISSUE: state_d = WAIT_BUSY;
                WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (sfx_q == 2'd1) begin
                            sfx_d   = 2'd2;
                            state_d = ISSUE;
                        end else if (sfx_q == 2'd2) begin
                            state_d = FINISH;
                        end else if (last) begin
                            sfx_d   = CRLF ? 2'd1 : 2'd0;
                            state_d = CRLF ? ISSUE : FINISH;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = ISSUE;
                        end
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                    sfx_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_d == FINISH) idx_d = '0;
        if (state_d == ISSUE)
            tx_data_d = sfx_d == 2'd1 ? DATA_W'(8'h0D) : sfx_d == 2'd2 ? DATA_W'(8'h0A) : mem_q[idx_d];
        tx_start_d = state_d == ISSUE;
        done_d     = state_d == FINISH;
        busy_d     = state_d != IDLE;
    end

    // state, buffer and registered outputs; reset restores the "hello" image
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= (ADDR_W+1)'(5);
            sfx_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= init_byte(i);
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            sfx_q      <= sfx_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_q      <= mem_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign byte_idx = idx_q;
endmodule
